id_ex_pipe_reg: RTL and testbench

//  Parametrised ID->EX pipeline register for the hazard-aware RV32 pipeline.

---
 rtl/id_ex_pipe_reg.sv | 83 ++++++++
 tb/tb_id_ex_pipe_reg.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register with stall, flush, valid bit
// and a saturating bubble counter for performance debug.
module id_ex_pipe_reg #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 12,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              StallE,
  input  logic              FlushE,
  input  logic              ValidD,
  input  logic [CTRL_W-1:0] CtrlD,
  input  logic [XLEN-1:0]   RD1,
  input  logic [XLEN-1:0]   RD2,
  input  logic [XLEN-1:0]   PCD,
  input  logic [XLEN-1:0]   ImmExt_D,
  input  logic [XLEN-1:0]   PC_Plus4D,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] RdD,
  output logic              ValidE,
  output logic [CTRL_W-1:0] CtrlE,
  output logic [XLEN-1:0]   RD1E,
  output logic [XLEN-1:0]   RD2E,
  output logic [XLEN-1:0]   PCE,
  output logic [XLEN-1:0]   ImmExt_E,
  output logic [XLEN-1:0]   PC_Plus4E,
  output logic [REG_AW-1:0] RSD1_E,
  output logic [REG_AW-1:0] RSD2_E,
  output logic [REG_AW-1:0] RdE,
  output logic [CNT_W-1:0]  BubbleCount
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic load;
  logic bubble;
  logic cnt_sat;

  // A bubble is any non-held, non-reset edge that leaves the slot invalid.
  assign load    = !FlushE && !StallE;
  assign bubble  = FlushE || (load && !ValidD);
  assign cnt_sat = (BubbleCount == CNT_MAX);

  // Pipeline payload: reset > flush > stall > load.
  always_ff @(posedge clk) begin
    if (reset || FlushE) begin
      ValidE    <= 1'b0;
      CtrlE     <= '0;
      RD1E      <= '0;
      RD2E      <= '0;
      PCE       <= '0;
      ImmExt_E  <= '0;
      PC_Plus4E <= '0;
      RSD1_E    <= '0;
      RSD2_E    <= '0;
      RdE       <= '0;
    end else if (load) begin
      ValidE    <= ValidD;
      CtrlE     <= ValidD ? CtrlD : '0;
      RD1E      <= RD1;
      RD2E      <= RD2;
      PCE       <= PCD;
      ImmExt_E  <= ImmExt_D;
      PC_Plus4E <= PC_Plus4D;
      RSD1_E    <= Rs1D;
      RSD2_E    <= Rs2D;
      RdE       <= ValidD ? RdD : '0;
    end
  end

  // Saturating bubble counter; held during a plain stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      BubbleCount <= '0;
    end else if (bubble && !cnt_sat) begin
      BubbleCount <= BubbleCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Randomised bench for id_ex_pipe_reg against a
// transaction-level model; a CNT_W=2 copy checks saturation.
module tb_id_ex_pipe_reg;
  localparam int XLEN = 32;
  localparam int RAW  = 5;
  localparam int CW   = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, StallE, FlushE, ValidD;
  logic [CW-1:0]   CtrlD;
  logic [XLEN-1:0] RD1, RD2, PCD, ImmExt_D, PC_Plus4D;
  logic [RAW-1:0]  Rs1D, Rs2D, RdD;

  logic            ValidE, v2;
  logic [CW-1:0]   CtrlE, c2;
  logic [XLEN-1:0] RD1E, RD2E, PCE, ImmExt_E, PC_Plus4E;
  logic [XLEN-1:0] a2, b2, p2, i2, q2;
  logic [RAW-1:0]  RSD1_E, RSD2_E, RdE, s2, t2, r2;
  logic [15:0]     BubbleCount;
  logic [1:0]      bc2;

  id_ex_pipe_reg dut (
    .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE),
    .ValidD(ValidD), .CtrlD(CtrlD), .RD1(RD1), .RD2(RD2), .PCD(PCD),
    .ImmExt_D(ImmExt_D), .PC_Plus4D(PC_Plus4D), .Rs1D(Rs1D),
    .Rs2D(Rs2D), .RdD(RdD), .ValidE(ValidE), .CtrlE(CtrlE),
    .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .ImmExt_E(ImmExt_E),
    .PC_Plus4E(PC_Plus4E), .RSD1_E(RSD1_E), .RSD2_E(RSD2_E),
    .RdE(RdE), .BubbleCount(BubbleCount)
  );

  id_ex_pipe_reg #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE),
    .ValidD(ValidD), .CtrlD(CtrlD), .RD1(RD1), .RD2(RD2), .PCD(PCD),
    .ImmExt_D(ImmExt_D), .PC_Plus4D(PC_Plus4D), .Rs1D(Rs1D),
    .Rs2D(Rs2D), .RdD(RdD), .ValidE(v2), .CtrlE(c2),
    .RD1E(a2), .RD2E(b2), .PCE(p2), .ImmExt_E(i2),
    .PC_Plus4E(q2), .RSD1_E(s2), .RSD2_E(t2),
    .RdE(r2), .BubbleCount(bc2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the slot contents as plain values.
  logic            m_valid;
  logic [CW-1:0]   m_ctrl;
  logic [XLEN-1:0] m_rd1, m_rd2, m_pc, m_imm, m_pc4;
  logic [RAW-1:0]  m_rs1, m_rs2, m_rd;
  int              m_bubbles;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (reset || FlushE) begin
      {m_valid, m_ctrl, m_rd1, m_rd2, m_pc} = '0;
      {m_imm, m_pc4, m_rs1, m_rs2, m_rd} = '0;
      if (reset) m_bubbles = 0;
      else       m_bubbles++;
    end else if (!StallE) begin
      m_valid = ValidD;
      m_ctrl  = ValidD ? CtrlD : '0;
      m_rd    = ValidD ? RdD : '0;
      m_rd1   = RD1;
      m_rd2   = RD2;
      m_pc    = PCD;
      m_imm   = ImmExt_D;
      m_pc4   = PC_Plus4D;
      m_rs1   = Rs1D;
      m_rs2   = Rs2D;
      if (!ValidD) m_bubbles++;
    end
  endtask

  task automatic compare_all();
    int sat16, sat2;
    sat16 = (m_bubbles > 65535) ? 65535 : m_bubbles;
    sat2  = (m_bubbles > 3) ? 3 : m_bubbles;
    check("ValidE", 64'(ValidE), 64'(m_valid));
    check("CtrlE", 64'(CtrlE), 64'(m_ctrl));
    check("RD1E", 64'(RD1E), 64'(m_rd1));
    check("RD2E", 64'(RD2E), 64'(m_rd2));
    check("PCE", 64'(PCE), 64'(m_pc));
    check("ImmExt_E", 64'(ImmExt_E), 64'(m_imm));
    check("PC_Plus4E", 64'(PC_Plus4E), 64'(m_pc4));
    check("RSD1_E", 64'(RSD1_E), 64'(m_rs1));
    check("RSD2_E", 64'(RSD2_E), 64'(m_rs2));
    check("RdE", 64'(RdE), 64'(m_rd));
    check("BubbleCount", 64'(BubbleCount), 64'(sat16));
    check("BubbleCount2", 64'(bc2), 64'(sat2));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic rand_data();
    CtrlD     = CW'($urandom);
    RD1       = $urandom;
    RD2       = $urandom;
    PCD       = $urandom;
    ImmExt_D  = $urandom;
    PC_Plus4D = $urandom;
    Rs1D      = RAW'($urandom);
    Rs2D      = RAW'($urandom);
    RdD       = RAW'($urandom);
    ValidD    = 1'($urandom);
  endtask

  initial begin
    int bexp [5];
    bexp = '{1, 2, 3, 3, 3};
    m_bubbles = 0;
    {m_valid, m_ctrl, m_rd1, m_rd2, m_pc} = '0;
    {m_imm, m_pc4, m_rs1, m_rs2, m_rd} = '0;

    reset  = 1'b1;
    StallE = 1'($urandom);
    FlushE = 1'($urandom);
    rand_data();
    step();
    rand_data();
    step();
    check("rst_valid", 64'(ValidE), 64'd0);
    check("rst_cnt", 64'(BubbleCount), 64'd0);

    reset  = 1'b0;
    StallE = 1'b0;
    FlushE = 1'b0;
    rand_data();
    ValidD = 1'b1;
    RD1    = 32'h1234;
    RdD    = 5'd5;
    CtrlD  = 12'h0A5;
    step();
    check("ld_rd1", 64'(RD1E), 64'h1234);
    check("ld_rd", 64'(RdE), 64'd5);
    check("ld_ctrl", 64'(CtrlE), 64'h0A5);
    check("ld_valid", 64'(ValidE), 64'd1);
    check("ld_cnt", 64'(BubbleCount), 64'd0);

    StallE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_data();
      RD1 = 32'hFFFF;
      step();
      check("stall_rd1", 64'(RD1E), 64'h1234);
      check("stall_valid", 64'(ValidE), 64'd1);
      check("stall_cnt", 64'(BubbleCount), 64'd0);
    end

    FlushE = 1'b1;
    rand_data();
    step();
    check("fl_valid", 64'(ValidE), 64'd0);
    check("fl_ctrl", 64'(CtrlE), 64'd0);
    check("fl_rd", 64'(RdE), 64'd0);
    check("fl_rs1", 64'(RSD1_E), 64'd0);
    check("fl_cnt", 64'(BubbleCount), 64'd1);

    StallE = 1'b0;
    FlushE = 1'b0;
    rand_data();
    ValidD = 1'b0;
    RdD    = 5'd7;
    CtrlD  = 12'hFFF;
    step();
    check("nv_valid", 64'(ValidE), 64'd0);
    check("nv_rd", 64'(RdE), 64'd0);
    check("nv_ctrl", 64'(CtrlE), 64'd0);
    check("nv_cnt", 64'(BubbleCount), 64'd2);

    reset = 1'b1;
    step();
    reset  = 1'b0;
    FlushE = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rand_data();
      step();
      check("sat_cnt", 64'(bc2), 64'(bexp[i]));
    end
    FlushE = 1'b0;
    reset  = 1'b1;
    step();
    check("sat_rst", 64'(bc2), 64'd0);

    for (int i = 0; i < 400; i++) begin
      reset  = ($urandom_range(0, 39) == 0);
      FlushE = ($urandom_range(0, 9) == 0);
      StallE = ($urandom_range(0, 4) == 0);
      rand_data();
      ValidD = ($urandom_range(0, 9) < 7);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
